// File: rtl/commu_rx.sv
// commu_rx: 485 UART 8N1 receiver with EB 90 / len / payload / xor-checksum de-framing.
// Optional in-frame idle timeout is compiled in with `define COMMU_RX_TIMEOUT_EN.
module commu_rx #(
  parameter int BAUD_DIV     = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        rx_a,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic        rx_frm,
  output logic        rx_done,
  output logic        rx_ok,
  input  logic [15:0] fx_waddr,
  input  logic        fx_wr,
  input  logic [7:0]  fx_data,
  input  logic        fx_rd,
  input  logic [15:0] fx_raddr,
  output logic [7:0]  fx_q,
  input  logic [5:0]  mod_id
);

  // state    | meaning
  // B_IDLE   | line idle, waiting for a falling edge
  // B_START  | half-bit wait, confirm start bit still low
  // B_DATA   | sampling 8 data bits, LSB first
  // B_STOP   | sampling stop bit; after a bad stop, waiting for line high
  // F_HUNT1  | looking for 0xEB
  // F_HUNT2  | looking for 0x90
  // F_LEN    | next byte is payload length
  // F_PAY    | streaming payload bytes
  // F_CHK    | next byte is the xor checksum
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} b_state_t;
  typedef enum logic [2:0] {F_HUNT1, F_HUNT2, F_LEN, F_PAY, F_CHK} f_state_t;

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_TC = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(BAUD_DIV / 2 - 1);

  logic          sync1_q, sync2_q, rx_prev_q;
  logic          rx_s, rx_fall;
  b_state_t      b_state_q;
  logic [CW-1:0] b_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          brk_q;
  logic          byte_rdy_q;
  logic          frm_err_q;

  f_state_t      f_state_q;
  logic [7:0]    len_q;
  logic [7:0]    chk_q;
  logic [7:0]    rx_data_q;
  logic          rx_vld_q, rx_frm_q, rx_done_q, rx_ok_q;

  logic [7:0]    ok_cnt_q, chk_cnt_q, err_cnt_q;
  logic [7:0]    rd_mux;
  logic [7:0]    fx_q_q;
  logic          cnt_clr;

  logic          ev_len0, ev_chk_ok, ev_chk_bad, ev_timeout, ev_abort, err_inc;
  logic          unused_fx;

  assign unused_fx = ^fx_data;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_a;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q  <= B_IDLE;
      b_cnt_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (b_state_q)
        B_IDLE: begin
          if (rx_fall) begin
            b_cnt_q   <= HALF_TC;
            b_state_q <= B_START;
          end
        end
        B_START: begin
          if (b_cnt_q != '0) begin
            b_cnt_q <= b_cnt_q - 1'b1;
          end else if (rx_s) begin
            b_state_q <= B_IDLE;
          end else begin
            b_cnt_q   <= FULL_TC;
            bit_idx_q <= '0;
            b_state_q <= B_DATA;
          end
        end
        B_DATA: begin
          if (b_cnt_q != '0) begin
            b_cnt_q <= b_cnt_q - 1'b1;
          end else begin
            shift_q   <= {rx_s, shift_q[7:1]};
            b_cnt_q   <= FULL_TC;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) b_state_q <= B_STOP;
          end
        end
        B_STOP: begin
          // A low stop bit may be a break; hold here until the line recovers.
          if (brk_q) begin
            if (rx_s) begin
              brk_q     <= 1'b0;
              b_state_q <= B_IDLE;
            end
          end else if (b_cnt_q != '0) begin
            b_cnt_q <= b_cnt_q - 1'b1;
          end else if (rx_s) begin
            byte_rdy_q <= 1'b1;
            b_state_q  <= B_IDLE;
          end else begin
            frm_err_q <= 1'b1;
            brk_q     <= 1'b1;
          end
        end
        default: b_state_q <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    ev_len0    = 1'b0;
    ev_chk_ok  = 1'b0;
    ev_chk_bad = 1'b0;
    if (byte_rdy_q) begin
      if (f_state_q == F_LEN && shift_q == 8'h00) ev_len0 = 1'b1;
      if (f_state_q == F_CHK) begin
        ev_chk_ok  = (shift_q == chk_q);
        ev_chk_bad = (shift_q != chk_q);
      end
    end
  end

  assign ev_abort = (frm_err_q & rx_frm_q) | ev_len0 | ev_timeout;
  assign err_inc  = frm_err_q | ev_len0 | ev_timeout;

`ifdef COMMU_RX_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW     = $clog2(TO_CYC + 1);
  logic [TW-1:0] idle_cnt_q;
  logic          idle_run;

  assign idle_run   = rx_frm_q && (b_state_q == B_IDLE) && !rx_fall;
  assign ev_timeout = idle_run && (idle_cnt_q == '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                     idle_cnt_q <= '0;
    else if (!idle_run || ev_timeout) idle_cnt_q <= TW'(TO_CYC - 1);
    else                            idle_cnt_q <= idle_cnt_q - 1'b1;
  end
`else
  assign ev_timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      f_state_q <= F_HUNT1;
      len_q     <= '0;
      chk_q     <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_frm_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_ok_q   <= 1'b0;
    end else begin
      rx_vld_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_ok_q   <= 1'b0;
      if (ev_abort) begin
        rx_done_q <= 1'b1;
        rx_frm_q  <= 1'b0;
        f_state_q <= F_HUNT1;
      end else if (byte_rdy_q) begin
        case (f_state_q)
          F_HUNT1: if (shift_q == 8'hEB) f_state_q <= F_HUNT2;
          F_HUNT2: begin
            if (shift_q == 8'h90) begin
              rx_frm_q  <= 1'b1;
              f_state_q <= F_LEN;
            end else if (shift_q != 8'hEB) begin
              f_state_q <= F_HUNT1;
            end
          end
          F_LEN: begin
            len_q     <= shift_q;
            chk_q     <= shift_q;
            f_state_q <= F_PAY;
          end
          F_PAY: begin
            rx_data_q <= shift_q;
            rx_vld_q  <= 1'b1;
            chk_q     <= chk_q ^ shift_q;
            len_q     <= len_q - 1'b1;
            if (len_q == 8'd1) f_state_q <= F_CHK;
          end
          F_CHK: begin
            rx_done_q <= 1'b1;
            rx_ok_q   <= ev_chk_ok;
            rx_frm_q  <= 1'b0;
            f_state_q <= F_HUNT1;
          end
          default: f_state_q <= F_HUNT1;
        endcase
      end
    end
  end

  assign cnt_clr = fx_wr && (fx_waddr[15:10] == mod_id) && (fx_waddr[9:0] == 10'h000);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q  <= '0;
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (cnt_clr) begin
      ok_cnt_q  <= '0;
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (ev_chk_ok && ok_cnt_q != 8'hFF)   ok_cnt_q  <= ok_cnt_q + 1'b1;
      if (ev_chk_bad && chk_cnt_q != 8'hFF) chk_cnt_q <= chk_cnt_q + 1'b1;
      if (err_inc && err_cnt_q != 8'hFF)    err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (fx_raddr[9:0])
      10'h000: rd_mux = ok_cnt_q;
      10'h001: rd_mux = chk_cnt_q;
      10'h002: rd_mux = err_cnt_q;
      10'h003: rd_mux = {6'b0, rx_frm_q, b_state_q != B_IDLE};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                  fx_q_q <= '0;
    else if (fx_rd && fx_raddr[15:10] == mod_id) fx_q_q <= rd_mux;
    else                                         fx_q_q <= '0;
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign rx_frm  = rx_frm_q;
  assign rx_done = rx_done_q;
  assign rx_ok   = rx_ok_q;
  assign fx_q    = fx_q_q;

endmodule
